// File: rtl/seq_acc_result_drain.sv
// Ping-pong receiver for MAC result vectors, drained as lane beats over valid/ready.
// Optional macro SEQ_ACC_DRAIN_RELU_EN clamps negative lanes to zero on capture.
module seq_acc_result_drain #(
  parameter int unsigned outputElements  = 32,
  parameter int unsigned accumulatorBits = 16,
  parameter int unsigned lanesPerBeat    = 8,
  localparam int unsigned numBeats       = outputElements / lanesPerBeat,
  localparam int unsigned BeatW          = (numBeats > 1) ? $clog2(numBeats) : 1
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            mac_valid_i,
  input  logic [outputElements-1:0][accumulatorBits-1:0]  mac_data_i,
  output logic [lanesPerBeat-1:0][accumulatorBits-1:0]    out_data_o,
  output logic                                            out_valid_o,
  input  logic                                            out_ready_i,
  output logic                                            out_last_o,
  output logic [BeatW-1:0]                                out_beat_o,
  output logic                                            busy_o,
  output logic                                            overflow_o,
  output logic [7:0]                                      drop_count_o,
  input  logic                                            overflow_clr_i
);

  if ((outputElements % lanesPerBeat) != 0) begin : g_bad_cfg
    $error("outputElements must be a multiple of lanesPerBeat");
  end

  // Beat-major view of a vector: element b*lanesPerBeat+j lives at [b][j].
  typedef logic [numBeats-1:0][lanesPerBeat-1:0][accumulatorBits-1:0] vec_t;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} occ_e;

  occ_e             state_q, state_d;
  vec_t             slot_q [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [BeatW-1:0] beat_q, beat_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       drop_q, drop_d;

  logic xfer, last_beat, last_xfer, slot_free, cap, drop;
  vec_t cap_data;

  function automatic vec_t relu(input vec_t v);
    vec_t r;
    r = v;
`ifdef SEQ_ACC_DRAIN_RELU_EN
    for (int unsigned b = 0; b < numBeats; b++) begin
      for (int unsigned j = 0; j < lanesPerBeat; j++) begin
        if (v[b][j][accumulatorBits-1]) r[b][j] = '0;
      end
    end
`endif
    return r;
  endfunction

  assign cap_data    = relu(mac_data_i);
  assign out_valid_o = (state_q != EMPTY);
  assign busy_o      = (state_q != EMPTY);
  assign last_beat   = (beat_q == BeatW'(numBeats - 1));
  assign out_last_o  = out_valid_o && last_beat;
  assign out_beat_o  = beat_q;
  assign out_data_o  = slot_q[rd_ptr_q][beat_q];
  assign overflow_o  = ovf_q;
  assign drop_count_o = drop_q;

  assign xfer      = out_valid_o && out_ready_i;
  assign last_xfer = xfer && last_beat;
  // A full buffer still accepts when the draining slot frees on this very edge.
  assign slot_free = (state_q != FULL) || last_xfer;
  assign cap       = mac_valid_i && slot_free;
  assign drop      = mac_valid_i && !slot_free;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q ^ cap;
    rd_ptr_d = rd_ptr_q ^ last_xfer;
    beat_d   = beat_q;
    ovf_d    = ovf_q;
    drop_d   = drop_q;

    case (state_q)
      EMPTY:   if (cap) state_d = ONE;
      ONE: begin
        if (cap && !last_xfer)      state_d = FULL;
        else if (!cap && last_xfer) state_d = EMPTY;
      end
      FULL:    if (!cap && last_xfer) state_d = ONE;
      default: state_d = EMPTY;
    endcase

    if (xfer) beat_d = last_beat ? '0 : beat_q + BeatW'(1);

    if (drop) begin
      ovf_d  = 1'b1;
      drop_d = overflow_clr_i ? 8'd1 : ((drop_q == 8'hFF) ? 8'hFF : drop_q + 8'd1);
    end else if (overflow_clr_i) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= EMPTY;
      slot_q[0] <= '0;
      slot_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      beat_q   <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      beat_q   <= beat_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
      if (cap) slot_q[wr_ptr_q] <= cap_data;
    end
  end

endmodule

// File: tb/tb_seq_acc_result_drain.sv
// Directed testbench for seq_acc_result_drain (default parameters, 4 beats of 8 lanes).
module tb_seq_acc_result_drain;

  typedef logic [31:0][15:0] vec_t;
  typedef logic [7:0][15:0]  beat_t;

  logic        clk, rst;
  logic        mac_valid_i;
  vec_t        mac_data_i;
  beat_t       out_data_o;
  logic        out_valid_o, out_ready_i, out_last_o;
  logic [1:0]  out_beat_o;
  logic        busy_o, overflow_o;
  logic [7:0]  drop_count_o;
  logic        overflow_clr_i;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  seq_acc_result_drain #(
    .outputElements(32),
    .accumulatorBits(16),
    .lanesPerBeat(8)
  ) dut (
    .clk(clk), .rst(rst),
    .mac_valid_i(mac_valid_i), .mac_data_i(mac_data_i),
    .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_last_o(out_last_o), .out_beat_o(out_beat_o),
    .busy_o(busy_o), .overflow_o(overflow_o), .drop_count_o(drop_count_o),
    .overflow_clr_i(overflow_clr_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mkvec(input int unsigned base);
    vec_t v;
    for (int unsigned k = 0; k < 32; k++) v[k] = 16'(base + k);
    return v;
  endfunction

  task automatic expect_beat(input string tag, input vec_t v, input int unsigned b);
    beat_t e;
    for (int unsigned j = 0; j < 8; j++) e[j] = v[b*8 + j];
    check($sformatf("%s.b%0d.valid", tag, b), out_valid_o, 1);
    check($sformatf("%s.b%0d.beat", tag, b), out_beat_o, b);
    check($sformatf("%s.b%0d.last", tag, b), out_last_o, (b == 3));
    check($sformatf("%s.b%0d.data", tag, b), out_data_o, e);
  endtask

  // Assumes out_ready_i is high: one beat per cycle.
  task automatic drain(input string tag, input vec_t v);
    for (int unsigned b = 0; b < 4; b++) begin
      expect_beat(tag, v, b);
      tick();
    end
  endtask

  task automatic push(input vec_t v);
    mac_valid_i = 1'b1;
    mac_data_i  = v;
    tick();
    mac_valid_i = 1'b0;
  endtask

  vec_t va, vb, vc, vd, vh, vh_exp;
  int unsigned bcnt;

  initial begin
    rst = 1'b1; mac_valid_i = 1'b0; mac_data_i = '0;
    out_ready_i = 1'b0; overflow_clr_i = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // 1. reset state and a single vector
    check("rst.valid", out_valid_o, 0);
    check("rst.last", out_last_o, 0);
    check("rst.beat", out_beat_o, 0);
    check("rst.data", out_data_o, 0);
    check("rst.busy", busy_o, 0);
    check("rst.ovf", overflow_o, 0);
    check("rst.drops", drop_count_o, 0);
    va = mkvec(0);
    out_ready_i = 1'b1;
    push(va);
    drain("basic", va);
    check("basic.busy", busy_o, 0);
    check("basic.valid_end", out_valid_o, 0);

    // 2. backpressure with ready 1,0,0 repeating
    vb = mkvec(16'h100);
    out_ready_i = 1'b0;
    push(vb);
    bcnt = 0;
    for (int unsigned i = 0; i < 40; i++) begin
      if (bcnt < 4) begin
        out_ready_i = (i % 3 == 0);
        expect_beat("bp", vb, bcnt);
        tick();
        if (out_ready_i) bcnt++;
      end
    end
    check("bp.count", bcnt, 4);
    check("bp.busy", busy_o, 0);

    // 3. overflow: third vector dropped
    va = mkvec(16'h200); vb = mkvec(16'h300); vc = mkvec(16'h400);
    out_ready_i = 1'b0;
    push(va); push(vb); push(vc);
    check("ovf.flag", overflow_o, 1);
    check("ovf.drops", drop_count_o, 1);
    check("ovf.busy", busy_o, 1);
    out_ready_i = 1'b1;
    drain("ovfA", va);
    drain("ovfB", vb);
    check("ovf.busy_end", busy_o, 0);

    // 4. capture while FULL, coincident with the last beat
    va = mkvec(16'h500); vb = mkvec(16'h600); vd = mkvec(16'h700);
    out_ready_i = 1'b0;
    push(va); push(vb);
    out_ready_i = 1'b1;
    for (int unsigned b = 0; b < 3; b++) begin
      expect_beat("edgeA", va, b);
      tick();
    end
    expect_beat("edgeA", va, 3);
    push(vd);
    check("edge.drops", drop_count_o, 1);
    drain("edgeB", vb);
    drain("edgeD", vd);
    check("edge.busy", busy_o, 0);

    // 5. clear vs. drop, clear alone, saturation
    out_ready_i = 1'b0;
    push(mkvec(16'h800)); push(mkvec(16'h900));
    overflow_clr_i = 1'b1;
    push(mkvec(16'hA00));
    overflow_clr_i = 1'b0;
    check("clr.set_wins.flag", overflow_o, 1);
    check("clr.set_wins.drops", drop_count_o, 1);
    overflow_clr_i = 1'b1;
    tick();
    overflow_clr_i = 1'b0;
    check("clr.flag", overflow_o, 0);
    check("clr.drops", drop_count_o, 0);
    mac_valid_i = 1'b1;
    repeat (300) tick();
    mac_valid_i = 1'b0;
    check("sat.drops", drop_count_o, 255);
    check("sat.flag", overflow_o, 1);

    // 6. async reset mid-vector; lane 16 (beat 2 lane 0) is negative
    rst = 1'b1; tick(); rst = 1'b0; tick();
    check("rst2.drops", drop_count_o, 0);
    vh = mkvec(16'h0A00);
    vh[16] = 16'hFFFB;
    vh_exp = vh;
`ifdef SEQ_ACC_DRAIN_RELU_EN
    vh_exp[16] = 16'h0000;
`endif
    out_ready_i = 1'b1;
    push(vh);
    expect_beat("ar", vh_exp, 0); tick();
    expect_beat("ar", vh_exp, 1); tick();
    expect_beat("ar", vh_exp, 2);
    #2 rst = 1'b1;
    #1;
    check("ar.valid", out_valid_o, 0);
    check("ar.last", out_last_o, 0);
    check("ar.beat", out_beat_o, 0);
    check("ar.data", out_data_o, 0);
    check("ar.busy", busy_o, 0);
    #1 rst = 1'b0;
    tick();
    check("ar.busy_after", busy_o, 0);
    check("ar.valid_after", out_valid_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
